trail_ram_ctrl: RTL and testbench

Write-port controller for the shared trail framebuffer RAM (640×480, one 8-bit code per pixel; the VGA scan owns the read port).
- Arbitrates block-write requests from player 1 and player 2 round-robin.
- Expands each granted request into 64 single-pixel writes covering one 8×8 block.
- Runs full-frame clear sequences on restart and after reset.
- Sits between the player modules and the RAM's `wraddress`/`data`/`wren` pins in the top level.

---
 rtl/trail_pkg.sv | 24 ++
 rtl/trail_ram_ctrl_if.sv | 30 +++
 rtl/rr_arbiter2.sv | 18 +
 rtl/trail_ram_ctrl.sv | 148 ++++++++++++++
 tb/tb_trail_ram_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/trail_pkg.sv
// rtl/trail_pkg.sv - shared constants, state encoding and address helper for the trail framebuffer writer
package trail_pkg;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int BLOCK    = 8;
  localparam int FB_WORDS = H_RES * V_RES;

  localparam logic [7:0] P1_CODE = 8'h01;
  localparam logic [7:0] P2_CODE = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ACK   = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // y*640 + x as two shifts and an add; assumes the 640-pixel line pitch.
  function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return ({9'd0, y} << 9) + ({9'd0, y} << 7) + {9'd0, x};
  endfunction

endpackage

// File: rtl/trail_ram_ctrl_if.sv
// rtl/trail_ram_ctrl_if.sv - player request/ack handshake and RAM write-port bundle
interface trail_ram_ctrl_if;
  import trail_pkg::*;

  logic        clear_req;
  logic        req1;
  logic        req2;
  logic [9:0]  x1;
  logic [9:0]  y1;
  logic [9:0]  x2;
  logic [9:0]  y2;
  logic        ack1;
  logic        ack2;
  logic [18:0] wraddress;
  logic [7:0]  data;
  logic        wren;
  logic        busy;
  logic        clear_busy;

  modport master (
    output clear_req, req1, req2, x1, y1, x2, y2,
    input  ack1, ack2, wraddress, data, wren, busy, clear_busy
  );

  modport slave (
    input  clear_req, req1, req2, x1, y1, x2, y2,
    output ack1, ack2, wraddress, data, wren, busy, clear_busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter; last_grant is held by the parent
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);

  // last_grant = 1 means player 2 was served last, so player 1 wins a tie.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

endmodule

// File: rtl/trail_ram_ctrl.sv
// rtl/trail_ram_ctrl.sv - trail framebuffer write-port controller: 8x8 block fills and full-frame clears
module trail_ram_ctrl #(
  parameter int         H_RES          = trail_pkg::H_RES,
  parameter int         V_RES          = trail_pkg::V_RES,
  parameter int         BLOCK          = trail_pkg::BLOCK,
  parameter logic [7:0] P1_CODE        = trail_pkg::P1_CODE,
  parameter logic [7:0] P2_CODE        = trail_pkg::P2_CODE,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  trail_ram_ctrl_if.slave  bus
);
  import trail_pkg::*;

  localparam int                BLK_W      = $clog2(BLOCK);
  localparam int                CNT_W      = 2 * BLK_W;
  localparam logic [CNT_W-1:0]  CNT_LAST   = '1;
  localparam logic [BLK_W-1:0]  COL_LAST   = '1;
  localparam logic [18:0]       CLEAR_LAST = 19'(H_RES * V_RES - 1);
  localparam logic [18:0]       ROW_STEP   = 19'(H_RES - BLOCK + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nxt;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              last_grant_q, last_grant_d;
  logic              clear_pend_q, clear_pend_d;
  logic [18:0]       wraddress_q, wraddress_d;
  logic [7:0]        data_q, data_d;
  logic              wren_q, wren_d;
  logic              ack1_q, ack1_d, ack2_q, ack2_d;
  logic [1:0]        grant;
  logic [9:0]        gx, gy;

  // 11-bit sums so a block starting near x=1023 cannot wrap back into the frame.
  function automatic logic in_frame(input logic [9:0] x, input logic [9:0] y,
                                    input logic [CNT_W-1:0] cnt);
    logic [10:0] px, py;
    px = {1'b0, x} + 11'(cnt[BLK_W-1:0]);
    py = {1'b0, y} + 11'(cnt[CNT_W-1:BLK_W]);
    return (px < 11'(H_RES)) && (py < 11'(V_RES));
  endfunction

  rr_arbiter2 u_arb (
    .req        ({bus.req2, bus.req1}),
    .last_grant (last_grant_q),
    .en         ((state_q == IDLE) && !clear_pend_q && !bus.clear_req),
    .grant      (grant)
  );

  assign gx      = grant[1] ? bus.x2 : bus.x1;
  assign gy      = grant[1] ? bus.y2 : bus.y1;
  assign cnt_nxt = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    last_grant_d = last_grant_q;
    clear_pend_d = clear_pend_q;
    wraddress_d  = wraddress_q;
    data_d       = data_q;
    wren_d       = 1'b0;
    ack1_d       = 1'b0;
    ack2_d       = 1'b0;
    if (bus.clear_req && (state_q == FILL || state_q == ACK)) clear_pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (clear_pend_q || bus.clear_req) begin
          state_d      = CLEAR;
          clear_pend_d = 1'b0;
          wraddress_d  = '0;
          data_d       = '0;
          wren_d       = 1'b1;
        end else if (grant != 2'b00) begin
          state_d      = FILL;
          x_d          = gx;
          y_d          = gy;
          last_grant_d = grant[1];
          cnt_d        = '0;
          wraddress_d  = pix_addr(gx, gy);
          data_d       = grant[1] ? P2_CODE : P1_CODE;
          wren_d       = in_frame(gx, gy, '0);
        end
      end
      FILL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ACK;
          ack1_d  = !last_grant_q;
          ack2_d  = last_grant_q;
        end else begin
          // Address advances even for clipped pixels so the next row lines up.
          cnt_d       = cnt_nxt;
          wraddress_d = wraddress_q + ((cnt_q[BLK_W-1:0] == COL_LAST) ? ROW_STEP : 19'd1);
          wren_d      = in_frame(x_q, y_q, cnt_nxt);
        end
      end
      ACK: state_d = IDLE;
      CLEAR: begin
        if (wraddress_q == CLEAR_LAST) begin
          state_d = IDLE;
        end else begin
          wraddress_d = wraddress_q + 19'd1;
          wren_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      last_grant_q <= 1'b1;
      clear_pend_q <= CLEAR_ON_RESET;
      wraddress_q  <= '0;
      data_q       <= '0;
      wren_q       <= 1'b0;
      ack1_q       <= 1'b0;
      ack2_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      last_grant_q <= last_grant_d;
      clear_pend_q <= clear_pend_d;
      wraddress_q  <= wraddress_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
      ack1_q       <= ack1_d;
      ack2_q       <= ack2_d;
    end
  end

  assign bus.wraddress  = wraddress_q;
  assign bus.data       = data_q;
  assign bus.wren       = wren_q;
  assign bus.ack1       = ack1_q;
  assign bus.ack2       = ack2_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.clear_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_trail_ram_ctrl.sv
// tb/tb_trail_ram_ctrl.sv - scoreboard bench for trail_ram_ctrl with a 640x16 frame
module tb_trail_ram_ctrl;

  localparam int TB_H  = 640;
  localparam int TB_V  = 16;
  localparam int TB_FB = TB_H * TB_V;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int player;
    int cyc;
  } ack_t;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   cyc      = 0;
  int   wr_cnt   = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  wr_t  wr_q[$];
  ack_t ack_q[$];

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  trail_ram_ctrl_if bus ();

  trail_ram_ctrl #(
    .H_RES          (TB_H),
    .V_RES          (TB_V),
    .BLOCK          (8),
    .P1_CODE        (8'h01),
    .P2_CODE        (8'h80),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic push_block(input int x, input int y, input logic [7:0] code);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (x + c < TB_H && y + r < TB_V)
          wr_q.push_back('{addr: 19'((y + r) * TB_H + x + c), data: code});
  endtask

  task automatic push_clear();
    for (int a = 0; a < TB_FB; a++) wr_q.push_back('{addr: 19'(a), data: 8'h00});
  endtask

  task automatic push_ack(input int player, input int at);
    ack_q.push_back('{player: player, cyc: at});
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while ((bus.busy !== 1'b0 || bus.clear_busy !== 1'b0) && k < max) begin
      step();
      k++;
    end
    check("idle_reached", 32'(k < max), 1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or acks.
  initial begin
    int   run;
    wr_t  w;
    ack_t a;
    run = 0;
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        run = 0;
      end else begin
        if (bus.wren === 1'b1) begin
          wr_cnt++;
          check("write_expected", 32'(wr_q.size() != 0), 1);
          if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            check("write_addr", 32'(bus.wraddress), 32'(w.addr));
            check("write_data", 32'(bus.data), 32'(w.data));
          end
        end
        if (bus.ack1 === 1'b1 || bus.ack2 === 1'b1) begin
          check("ack_expected", 32'(ack_q.size() != 0), 1);
          check("ack_onehot", 32'(bus.ack1 & bus.ack2), 0);
          if (ack_q.size() != 0) begin
            a = ack_q.pop_front();
            check("ack_player", bus.ack2 ? 32'd2 : 32'd1, 32'(a.player));
            check("ack_cycle", 32'(cyc), 32'(a.cyc));
          end
        end
        if (bus.clear_busy === 1'b1) begin
          run++;
        end else if (run != 0) begin
          check("clear_busy_len", 32'(run), 32'(TB_FB));
          run = 0;
        end
      end
    end
  end

  initial begin
    #(20 * 80000);
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    int s;
    int w0;
    bus.clear_req = 1'b0;
    bus.req1 = 1'b0;
    bus.req2 = 1'b0;
    bus.x1 = '0; bus.y1 = '0;
    bus.x2 = '0; bus.y2 = '0;

    // Reset values, then the automatic clear from address 0.
    steps(3);
    check("rst_wren", 32'(bus.wren), 0);
    check("rst_addr", 32'(bus.wraddress), 0);
    check("rst_data", 32'(bus.data), 0);
    check("rst_ack", 32'({bus.ack1, bus.ack2}), 0);
    check("rst_busy", 32'({bus.busy, bus.clear_busy}), 0);
    push_clear();
    reset = 1'b0;
    step();
    check("clr0_wren", 32'(bus.wren), 1);
    check("clr0_addr", 32'(bus.wraddress), 0);
    check("clr0_busy", 32'(bus.clear_busy), 1);
    wait_idle(TB_FB + 100);
    check("post_clear_busy", 32'({bus.busy, bus.clear_busy}), 0);

    // Single player-1 block at (216,8): base 5336, last 9823.
    bus.x1 = 10'd216; bus.y1 = 10'd8; bus.req1 = 1'b1;
    s = cyc;
    push_block(216, 8, 8'h01);
    push_ack(1, s + 65);
    step();
    check("p1_first_addr", 32'(bus.wraddress), 32'd5336);
    check("p1_first_wren", 32'(bus.wren), 1);
    steps(63);
    check("p1_last_addr", 32'(bus.wraddress), 32'd9823);
    step();
    bus.req1 = 1'b0;
    step();

    // Clipped player-2 block at (636,12): 4x4 pixels in frame, first 8316.
    bus.x2 = 10'd636; bus.y2 = 10'd12; bus.req2 = 1'b1;
    s = cyc;
    w0 = wr_cnt;
    push_block(636, 12, 8'h80);
    push_ack(2, s + 65);
    step();
    check("p2clip_first_addr", 32'(bus.wraddress), 32'd8316);
    check("p2clip_first_data", 32'(bus.data), 32'h80);
    steps(64);
    bus.req2 = 1'b0;
    check("p2clip_writes", 32'(wr_cnt - w0), 32'd16);
    step();

    // Both held: P1, P2, P1, P2 at 66-cycle spacing.
    bus.x1 = 10'd0;   bus.y1 = 10'd0;
    bus.x2 = 10'd100; bus.y2 = 10'd4;
    bus.req1 = 1'b1; bus.req2 = 1'b1;
    s = cyc;
    push_block(0, 0, 8'h01);   push_ack(1, s + 65);
    push_block(100, 4, 8'h80); push_ack(2, s + 131);
    push_block(0, 0, 8'h01);   push_ack(1, s + 197);
    push_block(100, 4, 8'h80); push_ack(2, s + 263);
    steps(263);
    bus.req1 = 1'b0; bus.req2 = 1'b0;
    step();

    // clear_req during FILL: block finishes, clear runs, then the pending P2 block.
    bus.x1 = 10'd8;  bus.y1 = 10'd0;
    bus.x2 = 10'd16; bus.y2 = 10'd0;
    bus.req1 = 1'b1; bus.req2 = 1'b1;
    s = cyc;
    push_block(8, 0, 8'h01);
    push_ack(1, s + 65);
    push_clear();
    push_block(16, 0, 8'h80);
    push_ack(2, s + 66 + 1 + TB_FB + 65);
    steps(10);
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    steps(54);
    bus.req1 = 1'b0;
    steps(1 + TB_FB + 65 + 1);
    bus.req2 = 1'b0;
    step();

    // Reset at clear cycle 1000, then the clear restarts from 0.
    wait_idle(200);
    bus.clear_req = 1'b1;
    push_clear();
    step();
    bus.clear_req = 1'b0;
    check("clr_req_first_addr", 32'(bus.wraddress), 0);
    steps(999);
    reset = 1'b1;
    step();
    check("midrst_wren", 32'(bus.wren), 0);
    check("midrst_busy", 32'({bus.busy, bus.clear_busy}), 0);
    check("midrst_ack", 32'({bus.ack1, bus.ack2}), 0);
    wr_q.delete();
    step();
    reset = 1'b0;
    push_clear();
    step();
    check("restart_wren", 32'(bus.wren), 1);
    check("restart_addr", 32'(bus.wraddress), 0);
    wait_idle(TB_FB + 100);
    steps(2);

    check("writes_drained", 32'(wr_q.size()), 0);
    check("acks_drained", 32'(ack_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
